// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports (A = instruction fetch,
// B = load/store), the single-port RAM pins and the busy flag.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system's view: the requesters plus the RAM instance.
interface ram_arbiter_if #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 3
);
   // port A
   logic              a_req;
   logic              a_we;
   logic [AWIDTH-1:0] a_addr;
   logic [DWIDTH-1:0] a_wdata;
   logic              a_ack;
   logic [DWIDTH-1:0] a_rdata;
   // port B
   logic              b_req;
   logic              b_we;
   logic [AWIDTH-1:0] b_addr;
   logic [DWIDTH-1:0] b_wdata;
   logic              b_ack;
   logic [DWIDTH-1:0] b_rdata;
   // RAM side
   logic              ram_we;
   logic [AWIDTH-1:0] ram_addr;
   logic [DWIDTH-1:0] ram_wdata;
   logic [DWIDTH-1:0] ram_rdata;
   // status
   logic              busy;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata,
      output ram_we, ram_addr, ram_wdata,
      input  ram_rdata,
      output busy
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  ram_we, ram_addr, ram_wdata,
      output ram_rdata,
      input  busy
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM (synchronous write, combinational
// read) between port A (instruction fetch) and port B (load/store).
// At most one access is granted per clock. Each granted access is answered
// by a registered one-cycle ack, together with the read data that was
// captured on the same edge.
// Optional build macro RAM_ARBITER_FIXED_PRIO_EN: when it is defined, port A
// always wins contention. Otherwise contention is resolved round-robin.
module ram_arbiter #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 3
) (
   input logic           clk,
   input logic           reset,
   ram_arbiter_if.slave  bus
);

   // Registered state.
   logic              a_ack_reg,   a_ack_next;
   logic              b_ack_reg,   b_ack_next;
   logic [DWIDTH-1:0] a_rdata_reg, a_rdata_next;
   logic [DWIDTH-1:0] b_rdata_reg, b_rdata_next;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
   // Records the port granted most recently: 1 = B, 0 = A.
   logic              last_reg,    last_next;
`endif

   // Combinational grant.
   logic a_elig;
   logic b_elig;
   logic grant_a;
   logic grant_b;

   // A port whose ack is high is completing this cycle, so its request is
   // ignored for that cycle. This ack bubble is what makes port B get served
   // under continuous port A traffic.
   assign a_elig = bus.a_req & ~a_ack_reg;
   assign b_elig = bus.b_req & ~b_ack_reg;

   // Grant selection: a single eligible port is always granted.
`ifdef RAM_ARBITER_FIXED_PRIO_EN
   always_comb begin
      grant_a = a_elig;
      grant_b = b_elig & ~a_elig;
   end
`else
   always_comb begin
      grant_a = a_elig;
      grant_b = b_elig;
      if (a_elig && b_elig) begin
         grant_a = last_reg;
         grant_b = ~last_reg;
      end
   end
`endif

   // State register: acks, captured read data and round-robin history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_ack_reg   <= 1'b0;
         b_ack_reg   <= 1'b0;
         a_rdata_reg <= '0;
         b_rdata_reg <= '0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
         last_reg    <= 1'b1;
`endif
      end else begin
         a_ack_reg   <= a_ack_next;
         b_ack_reg   <= b_ack_next;
         a_rdata_reg <= a_rdata_next;
         b_rdata_reg <= b_rdata_next;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
         last_reg    <= last_next;
`endif
      end
   end

   // Next state: ack the granted port and capture the RAM output. On a write
   // the captured value is the old contents, because the RAM updates on this
   // same edge. The read data registers hold their value when there is no grant.
   always_comb begin
      a_ack_next   = grant_a;
      b_ack_next   = grant_b;
      a_rdata_next = a_rdata_reg;
      b_rdata_next = b_rdata_reg;
      if (grant_a) a_rdata_next = bus.ram_rdata;
      if (grant_b) b_rdata_next = bus.ram_rdata;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
      last_next = last_reg;
      if (grant_a)      last_next = 1'b0;
      else if (grant_b) last_next = 1'b1;
`endif
   end

   // Outputs: the RAM is driven from the granted port and defaults to port A.
   // The write enable is gated by reset, so an access interrupted by reset
   // cannot corrupt memory.
   always_comb begin
      bus.ram_addr  = bus.a_addr;
      bus.ram_wdata = bus.a_wdata;
      if (grant_b) begin
         bus.ram_addr  = bus.b_addr;
         bus.ram_wdata = bus.b_wdata;
      end
      bus.ram_we  = ((grant_a & bus.a_we) | (grant_b & bus.b_we)) & ~reset;
      bus.busy    = grant_a | grant_b;
      bus.a_ack   = a_ack_reg;
      bus.b_ack   = b_ack_reg;
      bus.a_rdata = a_rdata_reg;
      bus.b_rdata = b_rdata_reg;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter. It models the single-port RAM
// (combinational read, write on the clock edge) and checks the arbiter's
// outputs against hand-computed values.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   a_cnt;
   int   b_cnt;

   ram_arbiter_if #(.DWIDTH(16), .AWIDTH(3)) bus ();

   ram_arbiter #(.DWIDTH(16), .AWIDTH(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RAM model
   logic [15:0] mem [8];
   assign bus.ram_rdata = mem[bus.ram_addr];
   always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // single uncontended B write: grant cycle, then ack cycle
   task automatic b_write(input logic [2:0] addr, input logic [15:0] data);
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = addr; bus.b_wdata = data;
      #2 chk("b_wr_grant_we", bus.ram_we, 1'b1);
      step();
      chk("b_wr_ack", bus.b_ack, 1'b1);
      bus.b_req = 1'b0;
      step();
   endtask

   initial begin
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 3'd7; bus.a_wdata = 16'hDEAD;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 3'd0; bus.b_wdata = 16'h0;
      step();
      step();
      // reset state; ram_we is forced low even though A requests a write
      chk("rst_a_ack", bus.a_ack, 1'b0);
      chk("rst_b_ack", bus.b_ack, 1'b0);
      chk("rst_a_rdata", bus.a_rdata, 16'h0);
      chk("rst_b_rdata", bus.b_rdata, 16'h0);
      chk("rst_ram_we", bus.ram_we, 1'b0);
      bus.a_req = 1'b0;
      reset = 1'b0;

      // T1: A writes 0x1234 to addr 5, then reads it back
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 3'd5; bus.a_wdata = 16'h1234;
      #2;
      chk("t1_busy", bus.busy, 1'b1);
      chk("t1_ram_we", bus.ram_we, 1'b1);
      chk("t1_ram_addr", bus.ram_addr, 3'd5);
      chk("t1_ram_wdata", bus.ram_wdata, 16'h1234);
      chk("t1_ack_before", bus.a_ack, 1'b0);
      step();
      chk("t1_wr_ack", bus.a_ack, 1'b1);
      chk("t1_ack_cycle_we", bus.ram_we, 1'b0);
      chk("t1_ack_cycle_busy", bus.busy, 1'b0);
      bus.a_req = 1'b0;
      step();
      chk("t1_ack_pulse", bus.a_ack, 1'b0);
      bus.a_req = 1'b1; bus.a_we = 1'b0;
      #2 chk("t1_rd_we", bus.ram_we, 1'b0);
      step();
      chk("t1_rd_ack", bus.a_ack, 1'b1);
      chk("t1_rd_data", bus.a_rdata, 16'h1234);
      bus.a_req = 1'b0;
      step();
      chk("t1_rdata_hold", bus.a_rdata, 16'h1234);

      // preload through port B; this leaves B as the most recent grant
      b_write(3'd7, 16'h7777);
      b_write(3'd1, 16'h0011);
      b_write(3'd2, 16'h0022);

      // T2: simultaneous reads, A wins the first contention
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd1;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 3'd2;
      #2 chk("t2_first_addr", bus.ram_addr, 3'd1);
      step();
      chk("t2_a_ack", bus.a_ack, 1'b1);
      chk("t2_a_rdata", bus.a_rdata, 16'h0011);
      chk("t2_b_wait", bus.b_ack, 1'b0);
      bus.a_req = 1'b0;
      #2 chk("t2_second_addr", bus.ram_addr, 3'd2);
      step();
      chk("t2_b_ack", bus.b_ack, 1'b1);
      chk("t2_b_rdata", bus.b_rdata, 16'h0022);
      chk("t2_a_done", bus.a_ack, 1'b0);
      bus.b_req = 1'b0;
      step();

      // T3: both request continuously for 8 accesses; the grants must alternate A,B
      bus.a_req = 1'b1; bus.b_req = 1'b1;
      a_cnt = 0; b_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("t3_a_ack_%0d", k), bus.a_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk($sformatf("t3_b_ack_%0d", k), bus.b_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
         if (bus.a_ack) a_cnt++;
         if (bus.b_ack) b_cnt++;
      end
      chk("t3_a_count", a_cnt, 4);
      chk("t3_b_count", b_cnt, 4);
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      step();

      // T4: B writes 0xBEEF to addr 3; A reads addr 3 in the next cycle
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 3'd3; bus.b_wdata = 16'hBEEF;
      step();
      chk("t4_b_ack", bus.b_ack, 1'b1);
      bus.b_req = 1'b0;
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd3;
      step();
      chk("t4_a_ack", bus.a_ack, 1'b1);
      chk("t4_raw_data", bus.a_rdata, 16'hBEEF);
      bus.a_req = 1'b0;
      step();

      // T5: contention immediately after A was served
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd1;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 3'd2;
      #2;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      chk("t5_prio_addr", bus.ram_addr, 3'd1);
      step();
      chk("t5_prio_a_ack", bus.a_ack, 1'b1);
      chk("t5_prio_b_ack", bus.b_ack, 1'b0);
`else
      chk("t5_rr_addr", bus.ram_addr, 3'd2);
      step();
      chk("t5_rr_b_ack", bus.b_ack, 1'b1);
      chk("t5_rr_a_ack", bus.a_ack, 1'b0);
`endif
      step();
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      step();
      step();

      // T6: reset asserted while B is granted a write of 0x5555 to addr 7
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 3'd7; bus.b_wdata = 16'h5555;
      #1 chk("t6_pre_we", bus.ram_we, 1'b1);
      reset = 1'b1;
      #1;
      chk("t6_rst_we", bus.ram_we, 1'b0);
      chk("t6_rst_a_rdata", bus.a_rdata, 16'h0);
      chk("t6_rst_b_rdata", bus.b_rdata, 16'h0);
      step();
      chk("t6_rst_b_ack", bus.b_ack, 1'b0);
      bus.b_req = 1'b0;
      reset = 1'b0;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 3'd7;
      step();
      chk("t6_reissue_ack", bus.b_ack, 1'b1);
      chk("t6_addr7_unchanged", bus.b_rdata, 16'h7777);
      bus.b_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
